// File: rtl/add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer:
// FSM state encoding and the slice-index width helper.
package add_seq_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  typedef enum logic [ST_W-1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // A single-slice build still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder slice; the sequencer instantiates
// exactly one and reuses it for every slice of the operands.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer: processes N slices of W bits,
// LSB slice first, one per cycle, through a single shared adder slice.
//
// state | meaning
// IDLE  | ready for a request; last result still visible
// RUN   | one slice per cycle, carry held in c_q
// DONE  | result valid, held until io_out_ready
module multiword_add_seq
  import add_seq_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           io_in_valid,
  output logic           io_in_ready,
  input  logic [N*W-1:0] io_A,
  input  logic [N*W-1:0] io_B,
  input  logic           io_Cin,
  input  logic           io_Sub,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [N*W-1:0] io_Sum,
  output logic           io_Cout,
  output logic           io_Ovf,
  output logic           io_busy
);

  localparam int IDX_W = idx_w(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e           state;
  logic [N*W-1:0]   a_q;
  logic [N*W-1:0]   b_q;
  logic [N*W-1:0]   sum_q;
  logic             c_q;
  logic [IDX_W-1:0] idx;
  logic             cout_q;
  logic             ovf_q;

  logic [W-1:0]     slice_a;
  logic [W-1:0]     slice_b;
  logic [W-1:0]     slice_s;
  logic             slice_c;
  logic             slice_ovf;

  always_comb begin
    slice_a = a_q[idx*W +: W];
    slice_b = b_q[idx*W +: W];
  end

  adder_slice #(.W(W)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (c_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // b_q already holds ~B for subtract, so these are the post-inversion MSBs.
  assign slice_ovf = slice_a[W-1] ^ slice_b[W-1] ^ slice_s[W-1] ^ slice_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      idx    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            a_q   <= io_A;
            b_q   <= io_Sub ? ~io_B : io_B;
            c_q   <= io_Sub ? 1'b1 : io_Cin;
            idx   <= '0;
            sum_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*W +: W] <= slice_s;
          c_q               <= slice_c;
          if (idx == IDX_LAST) begin
            cout_q <= slice_c;
            ovf_q  <= slice_ovf;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (io_out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == DONE);
  assign io_busy      = (state == RUN) || (state == DONE);
  assign io_Sum       = sum_q;
  assign io_Cout      = cout_q;
  assign io_Ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (W=8, N=4) against a
// whole-word arithmetic reference model.
module tb_multiword_add_seq;

  localparam int W = 8;
  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          io_in_valid = 1'b0;
  logic          io_in_ready;
  logic [31:0]   io_A = '0;
  logic [31:0]   io_B = '0;
  logic          io_Cin = 1'b0;
  logic          io_Sub = 1'b0;
  logic          io_out_valid;
  logic          io_out_ready = 1'b0;
  logic [31:0]   io_Sum;
  logic          io_Cout;
  logic          io_Ovf;
  logic          io_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multiword_add_seq #(.W(W), .N(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_A         (io_A),
    .io_B         (io_B),
    .io_Cin       (io_Cin),
    .io_Sub       (io_Sub),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_Sum       (io_Sum),
    .io_Cout      (io_Cout),
    .io_Ovf       (io_Ovf),
    .io_busy      (io_busy)
  );

  // Whole-word reference: subtract is true A-B with Cout meaning "no borrow".
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, output logic [31:0] s, output logic co,
                       output logic ov);
    logic [32:0] wide;
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      ov = (a[31] != b[31]) && (s[31] != a[31]);
    end else begin
      wide = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      s  = wide[31:0];
      co = wide[32];
      ov = (a[31] == b[31]) && (s[31] != a[31]);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    io_A = a; io_B = b; io_Cin = cin; io_Sub = sub; io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!io_out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic release_out;
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", io_out_valid); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", io_busy); end
    checks++; if (io_Sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 00000000", io_Sum); end
    checks++; if ({io_Cout, io_Ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {io_Cout, io_Ovf}); end
    #11 reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", io_in_ready); end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic test_directed;
    vec_t v[6];
    int lat;
    v[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    v[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    v[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    v[3] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
    v[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    v[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      checks++; if (io_in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, io_in_ready); end
      start_op(v[i].a, v[i].b, v[i].cin, v[i].sub);
      wait_done(lat);
      checks++; if (lat != N) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, N); end
      checks++; if (io_Sum !== v[i].s) begin errors++; $display("FAIL dir%0d_sum: got %h expected %h", i, io_Sum, v[i].s); end
      checks++; if (io_Cout !== v[i].co) begin errors++; $display("FAIL dir%0d_cout: got %b expected %b", i, io_Cout, v[i].co); end
      checks++; if (io_Ovf !== v[i].ov) begin errors++; $display("FAIL dir%0d_ovf: got %b expected %b", i, io_Ovf, v[i].ov); end
      release_out();
      checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_out_valid_drop: got %b expected 0", i, io_out_valid); end
      checks++; if (io_Sum !== v[i].s) begin errors++; $display("FAIL dir%0d_sum_idle_hold: got %h expected %h", i, io_Sum, v[i].s); end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, s;
    logic cin, sub, co, ov;
    int lat;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      if (i % 5 == 0) a = {a[31], 31'h7FFFFFFF};
      if (i % 7 == 0) b = {b[31], 31'h0};
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      model(a, b, cin, sub, s, co, ov);
      start_op(a, b, cin, sub);
      wait_done(lat);
      checks++; if (lat != N) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, N); end
      checks++; if ({io_Sum, io_Cout, io_Ovf} !== {s, co, ov}) begin
        errors++;
        $display("FAIL rnd%0d_result a=%h b=%h cin=%b sub=%b: got %h/%b/%b expected %h/%b/%b",
                 i, a, b, cin, sub, io_Sum, io_Cout, io_Ovf, s, co, ov);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] s;
    logic co, ov;
    int lat;
    model(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, s, co, ov);
    io_A = 32'h12345678; io_B = 32'h0FEDCBA9; io_Cin = 1'b1; io_Sub = 1'b0;
    io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_A = 32'hDEADBEEF; io_B = 32'h01010101; io_Sub = 1'b1;
    lat = 0;
    while (!io_out_valid && lat < 20) begin
      checks++; if (io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_run_in_ready: got %b expected 0", io_in_ready); end
      @(posedge clock); #1;
      lat++;
    end
    checks++; if (lat != N) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, N); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, io_out_valid); end
      checks++; if ({io_Sum, io_Cout, io_Ovf} !== {s, co, ov}) begin
        errors++; $display("FAIL bp_hold_result%0d: got %h/%b/%b expected %h/%b/%b", i, io_Sum, io_Cout, io_Ovf, s, co, ov);
      end
      checks++; if (io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_done_in_ready%0d: got %b expected 0", i, io_in_ready); end
    end
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
    io_in_valid = 1'b0;
    checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", io_out_valid); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept_in_done: got busy %b expected 0", io_busy); end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] s;
    logic co, ov;
    int lat;
    start_op(32'hAAAA5555, 32'h5555AAAB, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    #2;
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b expected 0", io_busy); end
    checks++; if (io_Sum !== 32'h0) begin errors++; $display("FAIL rst_run_sum: got %h expected 00000000", io_Sum); end
    #2 reset = 1'b1;
    @(posedge clock); #1;
    checks++; if ({io_in_ready, io_out_valid, io_busy} !== 3'b100) begin
      errors++; $display("FAIL rst_run_after_release: got ready/valid/busy %b expected 100", {io_in_ready, io_out_valid, io_busy});
    end
    checks++; if (io_Sum !== 32'h0) begin errors++; $display("FAIL rst_run_sum_after: got %h expected 00000000", io_Sum); end
    model(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, s, co, ov);
    start_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat != N) begin errors++; $display("FAIL rst_next_latency: got %0d expected %0d", lat, N); end
    checks++; if ({io_Sum, io_Cout, io_Ovf} !== {s, co, ov}) begin
      errors++; $display("FAIL rst_next_result: got %h/%b/%b expected %h/%b/%b", io_Sum, io_Cout, io_Ovf, s, co, ov);
    end
    release_out();
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b, s;
    logic cin, sub, co, ov;
    int acc_prev, acc_now, bound;
    acc_prev = 0;
    io_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'(i % 2);
      model(a, b, cin, sub, s, co, ov);
      io_A = a; io_B = b; io_Cin = cin; io_Sub = sub; io_in_valid = 1'b1;
      bound = 0;
      while (!io_in_ready && bound < 20) begin @(posedge clock); #1; bound++; end
      @(posedge clock); #1;
      acc_now = cyc;
      if (i > 0) begin
        checks++; if (acc_now - acc_prev != N + 2) begin
          errors++; $display("FAIL b2b%0d_spacing: got %0d expected %0d", i, acc_now - acc_prev, N + 2);
        end
      end
      acc_prev = acc_now;
      bound = 0;
      while (!io_out_valid && bound < 20) begin @(posedge clock); #1; bound++; end
      checks++; if ({io_Sum, io_Cout, io_Ovf} !== {s, co, ov}) begin
        errors++; $display("FAIL b2b%0d_result: got %h/%b/%b expected %h/%b/%b", i, io_Sum, io_Cout, io_Ovf, s, co, ov);
      end
    end
    io_in_valid = 1'b0;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL b2b_final_idle: got busy %b expected 0", io_busy); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
